rr_one_picker: RTL and testbench

- Parametrised successor to the combinational trailing-one detector.
- Performs a rotating-priority search for up to NUM_PICK set bits in a request vector. The search starts at an internal priority pointer and wraps around.
- Result is registered behind a valid/ready handshake.
- Intended for RV32I issue-select and free-list allocation, where fixed bit-0 priority starves high indices.

---
 rtl/rr_one_picker.sv | 100 ++++++++++
 tb/tb_rr_one_picker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_one_picker.sv
// Rotating-priority picker: grants up to NUM_PICK set bits of a request vector,
// searching from a priority pointer that advances past the last grant.
module rr_one_picker #(
  parameter int VEC_LEN  = 8,
  parameter int NUM_PICK = 2,
  parameter int IDX_W    = $clog2(VEC_LEN)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [VEC_LEN-1:0]        i_req_vec,
  input  logic                      i_fixed_prio,
  output logic                      o_grant_valid,
  input  logic                      i_grant_ready,
  output logic [NUM_PICK*IDX_W-1:0] o_grant_pos,
  output logic [NUM_PICK-1:0]       o_grant_vld,
  output logic [VEC_LEN-1:0]        o_grant_mask,
  output logic                      o_all_zero,
  output logic [IDX_W-1:0]          o_ptr
);

  localparam logic [IDX_W:0] LEN_W = (IDX_W+1)'(VEC_LEN);

  logic                      accept;
  logic [IDX_W-1:0]          start;
  logic [VEC_LEN-1:0]        remain;
  logic [NUM_PICK*IDX_W-1:0] nxt_pos;
  logic [NUM_PICK-1:0]       nxt_vld;
  logic [VEC_LEN-1:0]        nxt_mask;
  logic [IDX_W-1:0]          nxt_ptr;
  logic [IDX_W-1:0]          pick;
  logic [IDX_W-1:0]          last_pick;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W:0]            sum;
  logic                      found;

  assign o_req_ready = ~o_grant_valid | i_grant_ready;
  assign accept      = i_req_valid & o_req_ready;
  assign start       = i_fixed_prio ? '0 : o_ptr;

  // Each slot takes the first remaining bit in rotated order, then removes it
  // from the candidate set so later slots see only what is left.
  always_comb begin
    remain    = i_req_vec;
    nxt_pos   = '0;
    nxt_vld   = '0;
    nxt_mask  = '0;
    pick      = '0;
    last_pick = '0;
    idx       = '0;
    sum       = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_PICK; k++) begin
      found = 1'b0;
      pick  = '0;
      for (int j = 0; j < VEC_LEN; j++) begin
        sum = {1'b0, start} + (IDX_W+1)'(j);
        if (sum >= LEN_W) sum = sum - LEN_W;
        idx = sum[IDX_W-1:0];
        if (!found && remain[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
      if (found) begin
        nxt_vld[k]                   = 1'b1;
        nxt_pos[k*IDX_W +: IDX_W]    = pick;
        nxt_mask[pick]               = 1'b1;
        remain[pick]                 = 1'b0;
        last_pick                    = pick;
      end
    end
    // Wrap at VEC_LEN, not at 2**IDX_W, so padded indices are never reached.
    sum = {1'b0, last_pick} + (IDX_W+1)'(1);
    if (sum >= LEN_W) sum = sum - LEN_W;
    nxt_ptr = sum[IDX_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_valid <= 1'b0;
      o_grant_pos   <= '0;
      o_grant_vld   <= '0;
      o_grant_mask  <= '0;
      o_all_zero    <= 1'b0;
      o_ptr         <= '0;
    end else if (accept) begin
      o_grant_valid <= 1'b1;
      o_grant_pos   <= nxt_pos;
      o_grant_vld   <= nxt_vld;
      o_grant_mask  <= nxt_mask;
      o_all_zero    <= ~|i_req_vec;
      if (!i_fixed_prio && nxt_vld[0]) o_ptr <= nxt_ptr;
    end else if (i_grant_ready) begin
      o_grant_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_one_picker.sv
// Directed bench for rr_one_picker: an 8-wide and a 6-wide instance, both NUM_PICK=2.
module tb_rr_one_picker;

  logic       clk;
  logic       rst_n;

  logic       req_valid, req_ready, fixed_prio, grant_valid, grant_ready, all_zero;
  logic [7:0] req_vec, grant_mask;
  logic [5:0] grant_pos;
  logic [1:0] grant_vld;
  logic [2:0] ptr;

  logic       req_valid_b, req_ready_b, fixed_prio_b, grant_valid_b, grant_ready_b, all_zero_b;
  logic [5:0] req_vec_b, grant_mask_b;
  logic [5:0] grant_pos_b;
  logic [1:0] grant_vld_b;
  logic [2:0] ptr_b;

  int n_checks = 0;
  int n_fail   = 0;

  rr_one_picker #(.VEC_LEN(8), .NUM_PICK(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_vec(req_vec), .i_fixed_prio(fixed_prio),
    .o_grant_valid(grant_valid), .i_grant_ready(grant_ready),
    .o_grant_pos(grant_pos), .o_grant_vld(grant_vld),
    .o_grant_mask(grant_mask), .o_all_zero(all_zero), .o_ptr(ptr)
  );

  rr_one_picker #(.VEC_LEN(6), .NUM_PICK(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid_b), .o_req_ready(req_ready_b),
    .i_req_vec(req_vec_b), .i_fixed_prio(fixed_prio_b),
    .o_grant_valid(grant_valid_b), .i_grant_ready(grant_ready_b),
    .o_grant_pos(grant_pos_b), .o_grant_vld(grant_vld_b),
    .o_grant_mask(grant_mask_b), .o_all_zero(all_zero_b), .o_ptr(ptr_b)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({grant_valid, grant_pos, grant_vld, grant_mask, all_zero} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", {grant_valid, grant_pos, grant_vld, grant_mask, all_zero});
    end
    n_checks++;
    if (ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d, expected 0", ptr); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, grant_valid} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_ready_valid: got %b, expected 10", {req_ready, grant_valid});
    end
  endtask

  task automatic test_rotate();
    req_valid = 1'b1; fixed_prio = 1'b0; req_vec = 8'b0010_1100;
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_vld, grant_pos} !== {1'b1, 2'b11, 3'd3, 3'd2}) begin
      n_fail++; $display("FAIL rot1_pos: got v=%b vld=%b pos=%h, expected v=1 vld=11 pos1=3 pos0=2", grant_valid, grant_vld, grant_pos);
    end
    n_checks++;
    if ({grant_mask, all_zero, ptr} !== {8'b0000_1100, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL rot1_mask_ptr: got mask=%b az=%b ptr=%0d, expected 00001100 0 4", grant_mask, all_zero, ptr);
    end
    req_vec = 8'b0010_1100;
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_vld, grant_pos} !== {1'b1, 2'b11, 3'd2, 3'd5}) begin
      n_fail++; $display("FAIL rot2_wrap_pos: got v=%b vld=%b pos=%h, expected pos1=2 pos0=5", grant_valid, grant_vld, grant_pos);
    end
    n_checks++;
    if ({grant_mask, ptr} !== {8'b0010_0100, 3'd3}) begin
      n_fail++; $display("FAIL rot2_mask_ptr: got mask=%b ptr=%0d, expected 00100100 3", grant_mask, ptr);
    end
    req_vec = 8'b1000_0000;
    @(negedge clk);
    n_checks++;
    if ({grant_vld, grant_pos, grant_mask} !== {2'b01, 3'd0, 3'd7, 8'b1000_0000}) begin
      n_fail++; $display("FAIL rot3_single: got vld=%b pos=%h mask=%b, expected 01 pos0=7 pos1=0 10000000", grant_vld, grant_pos, grant_mask);
    end
    n_checks++;
    if (ptr !== 3'd0) begin n_fail++; $display("FAIL rot3_ptr_wrap: got %0d, expected 0", ptr); end
    req_vec = 8'b0;
    @(negedge clk);
    n_checks++;
    if ({grant_valid, all_zero, grant_vld, grant_mask, grant_pos, ptr} !== {1'b1, 1'b1, 2'b00, 8'h00, 6'h00, 3'd0}) begin
      n_fail++; $display("FAIL zero_req: got v=%b az=%b vld=%b mask=%b pos=%h ptr=%0d, expected 1 1 00 0 0 0",
                         grant_valid, all_zero, grant_vld, grant_mask, grant_pos, ptr);
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b, expected 0", grant_valid); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_vec = 8'b0010_1100;
    @(negedge clk);
    grant_ready = 1'b0; req_vec = 8'b1000_0001;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({grant_valid, grant_pos, grant_mask, ptr} !== {1'b1, 3'd3, 3'd2, 8'b0000_1100, 3'd4}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v=%b pos=%h mask=%b ptr=%0d, expected 1 pos1=3 pos0=2 00001100 4",
                           c, grant_valid, grant_pos, grant_mask, ptr);
      end
    end
    grant_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, expected 1", req_ready); end
    @(negedge clk);
    n_checks++;
    if ({grant_valid, grant_vld, grant_pos, grant_mask, ptr} !== {1'b1, 2'b11, 3'd0, 3'd7, 8'b1000_0001, 3'd1}) begin
      n_fail++; $display("FAIL bp_release_accept: got v=%b vld=%b pos=%h mask=%b ptr=%0d, expected 1 11 pos1=0 pos0=7 10000001 1",
                         grant_valid, grant_vld, grant_pos, grant_mask, ptr);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    req_valid = 1'b1; fixed_prio = 1'b0; req_vec = 8'b0001_0000;
    @(negedge clk);
    n_checks++;
    if ({grant_vld, grant_pos[2:0], ptr} !== {2'b01, 3'd4, 3'd5}) begin
      n_fail++; $display("FAIL fp_setup: got vld=%b pos0=%0d ptr=%0d, expected 01 4 5", grant_vld, grant_pos[2:0], ptr);
    end
    fixed_prio = 1'b1; req_vec = 8'b1000_0011;
    @(negedge clk);
    n_checks++;
    if ({grant_vld, grant_pos, grant_mask, ptr} !== {2'b11, 3'd1, 3'd0, 8'b0000_0011, 3'd5}) begin
      n_fail++; $display("FAIL fixed_prio: got vld=%b pos=%h mask=%b ptr=%0d, expected 11 pos1=1 pos0=0 00000011 5",
                         grant_vld, grant_pos, grant_mask, ptr);
    end
    req_valid = 1'b0; fixed_prio = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    n_checks++;
    if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b, expected 1", grant_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant_valid, ptr} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL areset_immediate: got v=%b ptr=%0d, expected 0 0", grant_valid, ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vec6();
    req_valid_b = 1'b1; req_vec_b = 6'b01_0000;
    @(negedge clk);
    n_checks++;
    if (ptr_b !== 3'd5) begin n_fail++; $display("FAIL v6_setup_ptr: got %0d, expected 5", ptr_b); end
    req_vec_b = 6'b10_0001;
    @(negedge clk);
    n_checks++;
    if ({grant_valid_b, grant_vld_b, grant_pos_b, grant_mask_b} !== {1'b1, 2'b11, 3'd0, 3'd5, 6'b10_0001}) begin
      n_fail++; $display("FAIL v6_wrap_pos: got v=%b vld=%b pos=%h mask=%b, expected 1 11 pos1=0 pos0=5 100001",
                         grant_valid_b, grant_vld_b, grant_pos_b, grant_mask_b);
    end
    n_checks++;
    if (ptr_b !== 3'd1) begin n_fail++; $display("FAIL v6_ptr_wrap: got %0d, expected 1", ptr_b); end
    req_valid_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    req_valid = 1'b0; req_vec = '0; fixed_prio = 1'b0; grant_ready = 1'b1;
    req_valid_b = 1'b0; req_vec_b = '0; fixed_prio_b = 1'b0; grant_ready_b = 1'b1;
    test_reset();
    test_rotate();
    test_back_to_back();
    test_fixed_prio();
    test_async_reset();
    test_vec6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
